// File: rtl/seq_restoring_divider_pkg.sv
// Shared types for the sequential restoring divider.
// FSM state encoding and counter sizing helper.
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_sub_level.sv
// Ripple-borrow subtractor: a chain of full-subtractor cells.
// b_out=1 means a<b (unsigned).
module sub_level #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         b_out
);

  always_comb begin
    logic bw;
    bw   = 1'b0;
    diff = '0;
    for (int i = 0; i < N; i++) begin
      diff[i] = a[i] ^ b[i] ^ bw;
      bw = (~a[i] & b[i]) |
           (~(a[i] ^ b[i]) & bw);
    end
    b_out = bw;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider.
// One quotient bit per clock, start/done handshake.
module seq_restoring_divider #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import seq_restoring_divider_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dzo_q, dzo_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             unused_msb;

  assign a_sh = {a_q, q_q[WIDTH-1]};

  sub_level #(
    .N(WIDTH + 1)
  ) u_sub (
    .a    (a_sh),
    .b    ({1'b0, m_q}),
    .diff (trial),
    .b_out(borrow)
  );

  // a_sh[WIDTH] is zero on restore and trial[WIDTH] on success
  assign unused_msb = trial[WIDTH];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;
    done_d  = 1'b0;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            m_d     = divisor;
            q_d     = dividend;
            a_d     = '0;
            cnt_d   = CW'(WIDTH);
            dz_d    = 1'b0;
            state_d = S_RUN;
          end else begin
            a_d     = dividend;
            q_d     = '1;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      state_q == S_RUN: begin
        q_d   = {q_q[WIDTH-2:0], ~borrow};
        a_d   = borrow ? a_sh[WIDTH-1:0]
                       : trial[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      state_q == S_DONE: begin
        done_d  = 1'b1;
        quo_d   = q_q;
        rem_d   = a_q;
        dzo_d   = dz_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep bench for the restoring divider.
// Vectors carry hand-computed results; sweep uses / and %.
module tb_seq_restoring_divider;

  localparam int W = 7;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_pass = 0;
  int n_tot  = 0;

  seq_restoring_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           bsy;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  // Drives start immediately; returns one cycle after done
  task automatic run_op(input  logic [W-1:0] a,
                        input  logic [W-1:0] b,
                        input  bit           pchk,
                        output int           lat,
                        output int           bc,
                        output logic [W-1:0] q,
                        output logic [W-1:0] r,
                        output logic         dz);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    bc  = busy ? 1 : 0;
    lat = -1;
    q   = '0;
    r   = '0;
    dz  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (busy) bc++;
      if (done) begin
        lat = k;
        q   = quotient;
        r   = remainder;
        dz  = div_by_zero;
        break;
      end
    end
    if (pchk && lat > 0) begin
      @(posedge clk);
      #1;
      chk("done_pulse", int'(done), 0);
    end
  endtask

  int           lat, bc, nd, got;
  logic [W-1:0] q, r;
  logic         dz;
  int           dl[12];

  initial begin
    vecs[0] = '{7'd100, 7'd7,   7'd14,  7'd2,  1'b0, 8, 7};
    vecs[1] = '{7'd127, 7'd1,   7'd127, 7'd0,  1'b0, 8, 7};
    vecs[2] = '{7'd5,   7'd9,   7'd0,   7'd5,  1'b0, 8, 7};
    vecs[3] = '{7'd127, 7'd127, 7'd1,   7'd0,  1'b0, 8, 7};
    vecs[4] = '{7'd0,   7'd3,   7'd0,   7'd0,  1'b0, 8, 7};
    vecs[5] = '{7'd42,  7'd0,   7'd127, 7'd42, 1'b1, 1, 0};
    vecs[6] = '{7'd9,   7'd2,   7'd4,   7'd1,  1'b0, 8, 7};
    dl = '{1, 2, 3, 5, 7, 10, 13, 31, 64, 100, 126, 127};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quo", int'(quotient), 0);
    chk("rst_rem", int'(remainder), 0);
    chk("rst_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 1'b1,
             lat, bc, q, r, dz);
      chk("vec_lat", lat, vecs[i].lat);
      chk("vec_busy", bc, vecs[i].bsy);
      chk("vec_quo", int'(q), int'(vecs[i].q));
      chk("vec_rem", int'(r), int'(vecs[i].r));
      chk("vec_dz", int'(dz), int'(vecs[i].dz));
    end

    // start pulsed mid-operation must be ignored
    start    = 1'b1;
    dividend = 7'd100;
    divisor  = 7'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd    = 0;
    got   = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        start    = 1'b1;
        dividend = 7'd50;
        divisor  = 7'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        if (got < 0) begin
          got = k;
          q   = quotient;
          r   = remainder;
        end
      end
    end
    start = 1'b0;
    chk("ign_ndone", nd, 1);
    chk("ign_lat", got, 8);
    chk("ign_quo", int'(q), 14);
    chk("ign_rem", int'(r), 2);

    // reset mid-operation
    start    = 1'b1;
    dividend = 7'd100;
    divisor  = 7'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs",
        int'({busy, done, quotient,
              remainder, div_by_zero}), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    chk("post_rst_quiet", nd, 0);
    run_op(7'd60, 7'd8, 1'b1, lat, bc, q, r, dz);
    chk("rst_after_lat", lat, 8);
    chk("rst_after_quo", int'(q), 7);
    chk("rst_after_rem", int'(r), 4);
    chk("rst_after_dz", int'(dz), 0);

    // back-to-back sweep, start issued in the done cycle
    for (int a = 0; a < 128; a++) begin
      foreach (dl[j]) begin
        run_op(W'(a), W'(dl[j]), 1'b0,
               lat, bc, q, r, dz);
        chk("sw_lat", lat, 8);
        chk("sw_quo", int'(q), a / dl[j]);
        chk("sw_rem", int'(r), a % dl[j]);
        chk("sw_dz", int'(dz), 0);
      end
    end
    for (int n = 0; n < 400; n++) begin
      int a, b;
      a = int'($urandom_range(127, 0));
      b = int'($urandom_range(127, 1));
      run_op(W'(a), W'(b), 1'b0,
             lat, bc, q, r, dz);
      chk("rnd_lat", lat, 8);
      chk("rnd_quo", int'(q), a / b);
      chk("rnd_rem", int'(r), a % b);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
